// File: rtl/vector_ram_arb_pkg.sv
// Shared types, constants and the round-robin pick helper for vector_ram_arbiter.
package vector_ram_arb_pkg;

   localparam int unsigned DEF_NUM_REQ  = 4;
   localparam int unsigned DEF_ID_WIDTH = $clog2(DEF_NUM_REQ);
   localparam int unsigned STAT_WIDTH   = 32;

   // Requester ID for the default configuration
   typedef logic [DEF_ID_WIDTH-1:0] req_id_t;

   // Result of a round-robin scan: winning index and whether anyone was eligible
   typedef struct packed {
      logic       found;
      logic [7:0] id;
   } pick_t;

   // First set bit of mask scanning ptr, ptr+1, ... modulo n (n <= 32, ptr < n)
   function automatic pick_t rr_pick(input logic [31:0] mask,
                                     input logic [5:0]  ptr,
                                     input logic [5:0]  n);
      pick_t      r;
      logic [5:0] idx;
      r = '0;
      for (int k = 0; k < 32; k++) begin
         idx = ptr + 6'(k);
         if (idx >= n) idx = idx - n;
         if (!r.found && (6'(k) < n) && mask[idx[4:0]]) begin
            r.found = 1'b1;
            r.id    = 8'(idx);
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/vector_ram_arb_tag_fifo.sv
// In-order FIFO of requester IDs for reads still waiting on their response beat.
module vector_ram_arb_tag_fifo #(
   parameter int unsigned DEPTH = 8,
   parameter int unsigned W     = 2
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] din,
   output logic [W-1:0] dout,
   output logic         full,
   output logic         empty
);

   localparam int unsigned AW      = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

   logic [AW:0]  wr_ptr;
   logic [AW:0]  rd_ptr;
   logic [W-1:0] mem [DEPTH];
   logic         do_push;
   logic         do_pop;

   // Status flags and guarded push/pop strobes
   always_comb begin
      empty   = (wr_ptr == rd_ptr);
      full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
      do_push = push && !full;
      do_pop  = pop && !empty;
      dout    = mem[rd_ptr[AW-1:0]];
   end

   // Pointer update; reset discards all entries
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
         if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      end
   end

   // Storage write
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= din;
   end

endmodule

// File: rtl/vector_ram_arbiter.sv
// Round-robin arbiter sharing one vector_ram channel between NUM_REQ requesters.
// Optional statistics counters are enabled with `define VECTOR_RAM_ARB_STATS_EN.
module vector_ram_arbiter
   import vector_ram_arb_pkg::*;
#(
   parameter int unsigned NUM_REQ        = 4,
   parameter int unsigned PARALLELISM    = 4,
   parameter int unsigned ADDR_WIDTH     = 5,
   parameter int unsigned DATA_WIDTH     = 32,
   parameter int unsigned TAG_FIFO_DEPTH = 8
) (
   input  logic                                                   clk,
   input  logic                                                   rst,
   input  logic [NUM_REQ-1:0]                                     s_valid,
   output logic [NUM_REQ-1:0]                                     s_ready,
   input  logic [NUM_REQ-1:0]                                     s_write,
   input  logic [NUM_REQ-1:0][PARALLELISM-1:0][ADDR_WIDTH-1:0]    s_addr,
   input  logic [NUM_REQ-1:0][PARALLELISM-1:0][DATA_WIDTH-1:0]    s_wdata,
   output logic [NUM_REQ-1:0]                                     s_rvalid,
   input  logic [NUM_REQ-1:0]                                     s_rready,
   output logic [PARALLELISM-1:0][DATA_WIDTH-1:0]                 s_rdata,
   output logic                                                   m_valid,
   input  logic                                                   m_ready,
   output logic                                                   m_write,
   output logic [PARALLELISM-1:0][ADDR_WIDTH-1:0]                 m_addr,
   output logic [PARALLELISM-1:0][DATA_WIDTH-1:0]                 m_wdata,
   input  logic                                                   m_rvalid,
   output logic                                                   m_rready,
   input  logic [PARALLELISM-1:0][DATA_WIDTH-1:0]                 m_rdata,
   output logic                                                   err_orphan
`ifdef VECTOR_RAM_ARB_STATS_EN
   ,
   output logic [NUM_REQ-1:0][STAT_WIDTH-1:0]                     grant_cnt,
   output logic [NUM_REQ-1:0][STAT_WIDTH-1:0]                     stall_cnt
`endif
);

   localparam int unsigned         ID_WIDTH = $clog2(NUM_REQ);
   localparam logic [ID_WIDTH-1:0] ID_ONE   = ID_WIDTH'(1);
   localparam logic [ID_WIDTH-1:0] ID_LAST  = ID_WIDTH'(NUM_REQ - 1);

   typedef enum logic {ST_OPEN, ST_LOCKED} state_t;

   state_t              state;
   state_t              state_nxt;
   logic [ID_WIDTH-1:0] rr_ptr;
   logic [ID_WIDTH-1:0] rr_ptr_nxt;
   logic [ID_WIDTH-1:0] locked_id;
   logic [ID_WIDTH-1:0] locked_id_nxt;
   logic [ID_WIDTH-1:0] grant;
   logic [ID_WIDTH-1:0] head;
   logic [NUM_REQ-1:0]  eligible;
   pick_t               pick;
   logic                grant_ok;
   logic                hs;
   logic                tag_push;
   logic                tag_pop;
   logic                tag_full;
   logic                tag_empty;

   // Eligibility (reads blocked while the tag FIFO is full) and round-robin scan
   always_comb begin
      eligible = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         eligible[i] = s_valid[i] && (s_write[i] || !tag_full);
      end
      pick = rr_pick(32'(eligible), 6'(rr_ptr), 6'(NUM_REQ));
   end

   // Grant selection, request mux, and lock/pointer next-state
   always_comb begin
      state_nxt     = state;
      rr_ptr_nxt    = rr_ptr;
      locked_id_nxt = locked_id;
      s_ready       = '0;

      grant    = (state == ST_LOCKED) ? locked_id : pick.id[ID_WIDTH-1:0];
      grant_ok = (state == ST_LOCKED) || (pick.found && (pick.id < 8'(NUM_REQ)));

      m_valid = grant_ok && s_valid[grant];
      m_write = s_write[grant];
      m_addr  = s_addr[grant];
      m_wdata = s_wdata[grant];
      if (grant_ok) s_ready[grant] = m_ready;

      hs       = m_valid && m_ready;
      tag_push = hs && !m_write;

      if (hs) begin
         state_nxt  = ST_OPEN;
         rr_ptr_nxt = (grant == ID_LAST) ? '0 : grant + ID_ONE;
      end else if (m_valid) begin
         state_nxt     = ST_LOCKED;
         locked_id_nxt = grant;
      end
   end

   // Response routing to the requester at the head of the tag FIFO
   always_comb begin
      s_rvalid = '0;
      s_rdata  = m_rdata;
      m_rready = s_rready[head] && !tag_empty;
      if (!tag_empty) s_rvalid[head] = m_rvalid;
      tag_pop = m_rvalid && m_rready;
   end

   // Lock state and round-robin pointer registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= ST_OPEN;
         rr_ptr    <= '0;
         locked_id <= '0;
      end else begin
         state     <= state_nxt;
         rr_ptr    <= rr_ptr_nxt;
         locked_id <= locked_id_nxt;
      end
   end

   // Sticky flag for a response beat with no outstanding read
   always_ff @(posedge clk or posedge rst) begin
      if (rst) err_orphan <= 1'b0;
      else if (m_rvalid && tag_empty) err_orphan <= 1'b1;
   end

   vector_ram_arb_tag_fifo #(
      .DEPTH (TAG_FIFO_DEPTH),
      .W     (ID_WIDTH)
   ) u_tag_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (tag_push),
      .pop   (tag_pop),
      .din   (grant),
      .dout  (head),
      .full  (tag_full),
      .empty (tag_empty)
   );

`ifdef VECTOR_RAM_ARB_STATS_EN
   localparam logic [STAT_WIDTH-1:0] STAT_ONE = STAT_WIDTH'(1);

   // Saturating per-requester grant and stall counters
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         grant_cnt <= '0;
         stall_cnt <= '0;
      end else begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (hs && (grant == ID_WIDTH'(i)) && (grant_cnt[i] != '1))
               grant_cnt[i] <= grant_cnt[i] + STAT_ONE;
            if (s_valid[i] && !s_ready[i] && (stall_cnt[i] != '1))
               stall_cnt[i] <= stall_cnt[i] + STAT_ONE;
         end
      end
   end
`endif

endmodule

// File: tb/tb_vector_ram_arbiter.sv
// Directed self-checking bench for vector_ram_arbiter (default build).
module tb_vector_ram_arbiter;

   logic                  clk = 1'b0;
   logic                  rst;
   logic [3:0]            s_valid;
   logic [3:0]            s_ready;
   logic [3:0]            s_write;
   logic [3:0][3:0][4:0]  s_addr;
   logic [3:0][3:0][31:0] s_wdata;
   logic [3:0]            s_rvalid;
   logic [3:0]            s_rready;
   logic [3:0][31:0]      s_rdata;
   logic                  m_valid;
   logic                  m_ready;
   logic                  m_write;
   logic [3:0][4:0]       m_addr;
   logic [3:0][31:0]      m_wdata;
   logic                  m_rvalid;
   logic                  m_rready;
   logic [3:0][31:0]      m_rdata;
   logic                  err_orphan;

   int errors = 0;
   int checks = 0;
   int gcount [4];

   vector_ram_arbiter dut (
      .clk        (clk),
      .rst        (rst),
      .s_valid    (s_valid),
      .s_ready    (s_ready),
      .s_write    (s_write),
      .s_addr     (s_addr),
      .s_wdata    (s_wdata),
      .s_rvalid   (s_rvalid),
      .s_rready   (s_rready),
      .s_rdata    (s_rdata),
      .m_valid    (m_valid),
      .m_ready    (m_ready),
      .m_write    (m_write),
      .m_addr     (m_addr),
      .m_wdata    (m_wdata),
      .m_rvalid   (m_rvalid),
      .m_rready   (m_rready),
      .m_rdata    (m_rdata),
      .err_orphan (err_orphan)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Drive one requester; lane j address = base + j
   task automatic drive(input int i, input logic v, input logic w, input logic [4:0] base);
      s_valid[i] = v;
      s_write[i] = w;
      for (int j = 0; j < 4; j++) begin
         s_addr[i][j]  = base + 5'(j);
         s_wdata[i][j] = 32'(i * 256 + j);
      end
   endtask

   task automatic idle();
      s_valid = '0;
      s_write = '0;
   endtask

   initial begin
      rst      = 1'b1;
      s_valid  = '0;
      s_write  = '0;
      s_addr   = '0;
      s_wdata  = '0;
      s_rready = '0;
      m_ready  = 1'b0;
      m_rvalid = 1'b0;
      m_rdata  = '0;
      for (int i = 0; i < 4; i++) gcount[i] = 0;

      // Reset state
      repeat (2) @(negedge clk);
      #1;
      chk("rst_s_ready",  64'(s_ready),    64'(4'b0000));
      chk("rst_s_rvalid", 64'(s_rvalid),   64'(4'b0000));
      chk("rst_m_valid",  64'(m_valid),    64'(1'b0));
      chk("rst_orphan",   64'(err_orphan), 64'(1'b0));
      @(negedge clk);
      rst = 1'b0;

      // Fairness: four continuous writers, grants rotate 0,1,2,3
      for (int i = 0; i < 4; i++) drive(i, 1'b1, 1'b1, 5'(i * 4));
      m_ready = 1'b1;
      for (int k = 0; k < 16; k++) begin
         #1;
         chk("fair_grant", 64'(s_ready), 64'(4'b0001 << (k % 4)));
         chk("fair_addr",  64'(m_addr[0]), 64'(5'((k % 4) * 4)));
         for (int i = 0; i < 4; i++) if (s_ready[i]) gcount[i]++;
         @(negedge clk);
      end
      for (int i = 0; i < 4; i++) chk("fair_count", 64'(gcount[i]), 64'(4));

      // Back-pressure: req2 read held for 5 cycles; req1 joins while locked
      idle();
      m_ready = 1'b0;
      s_valid[2] = 1'b1;
      s_write[2] = 1'b0;
      for (int j = 0; j < 4; j++) s_addr[2][j] = 5'(j + 1);
      drive(3, 1'b1, 1'b1, 5'd20);
      for (int k = 0; k < 5; k++) begin
         if (k == 1) drive(1, 1'b1, 1'b1, 5'd8);
         #1;
         chk("bp_m_valid", 64'(m_valid), 64'(1'b1));
         chk("bp_m_write", 64'(m_write), 64'(1'b0));
         chk("bp_m_addr",  64'(m_addr),  64'({5'd4, 5'd3, 5'd2, 5'd1}));
         chk("bp_s_ready", 64'(s_ready), 64'(4'b0000));
         @(negedge clk);
      end
      m_ready = 1'b1;
      #1 chk("bp_release", 64'(s_ready), 64'(4'b0100));
      @(negedge clk);
      s_valid[2] = 1'b0;
      #1 chk("bp_next3", 64'(s_ready), 64'(4'b1000));
      @(negedge clk);
      s_valid[3] = 1'b0;
      #1 chk("bp_next1", 64'(s_ready), 64'(4'b0010));
      @(negedge clk);
      idle();
      m_rvalid = 1'b1;
      s_rready = 4'b1111;
      #1;
      chk("bp_tag_route", 64'(s_rvalid), 64'(4'b0100));
      chk("bp_tag_rready", 64'(m_rready), 64'(1'b1));
      @(negedge clk);
      m_rvalid = 1'b0;
      #1 chk("bp_tag_drained", 64'(s_rvalid), 64'(4'b0000));

      // Response routing: req1 then req3 read; 0xA to req1 (stalled 3 cycles), 0xB to req3
      drive(1, 1'b1, 1'b0, 5'd5);
      #1 chk("rr_req1", 64'(s_ready), 64'(4'b0010));
      @(negedge clk);
      idle();
      drive(3, 1'b1, 1'b0, 5'd9);
      #1 chk("rr_req3", 64'(s_ready), 64'(4'b1000));
      @(negedge clk);
      idle();
      m_rvalid = 1'b1;
      for (int j = 0; j < 4; j++) m_rdata[j] = 32'hA;
      s_rready = 4'b1101;
      for (int k = 0; k < 3; k++) begin
         #1;
         chk("rr_stall_rvalid", 64'(s_rvalid),   64'(4'b0010));
         chk("rr_stall_rready", 64'(m_rready),   64'(1'b0));
         chk("rr_stall_data",   64'(s_rdata[0]), 64'(32'hA));
         @(negedge clk);
      end
      s_rready = 4'b1111;
      #1 chk("rr_beat_a", 64'(m_rready), 64'(1'b1));
      @(negedge clk);
      for (int j = 0; j < 4; j++) m_rdata[j] = 32'hB;
      #1;
      chk("rr_beat_b_rvalid", 64'(s_rvalid),   64'(4'b1000));
      chk("rr_beat_b_data",   64'(s_rdata[3]), 64'(32'hB));
      chk("rr_beat_b_rready", 64'(m_rready),   64'(1'b1));
      @(negedge clk);
      m_rvalid = 1'b0;

      // Tag full: 8 reads outstanding, 9th read waits, write passes, read enters after a pop
      drive(0, 1'b1, 1'b0, 5'd0);
      for (int k = 0; k < 8; k++) begin
         #1 chk("full_fill", 64'(s_ready), 64'(4'b0001));
         @(negedge clk);
      end
      drive(1, 1'b1, 1'b1, 5'd12);
      #1;
      chk("full_write_ok", 64'(s_ready), 64'(4'b0010));
      chk("full_write_m",  64'(m_write), 64'(1'b1));
      @(negedge clk);
      s_valid[1] = 1'b0;
      #1;
      chk("full_read_blk", 64'(s_ready), 64'(4'b0000));
      chk("full_m_valid",  64'(m_valid), 64'(1'b0));
      @(negedge clk);
      m_rvalid = 1'b1;
      #1;
      chk("full_pop_rready", 64'(m_rready), 64'(1'b1));
      chk("full_pop_rvalid", 64'(s_rvalid), 64'(4'b0001));
      chk("full_same_cycle", 64'(s_ready),  64'(4'b0000));
      @(negedge clk);
      m_rvalid = 1'b0;
      #1 chk("full_after_pop", 64'(s_ready), 64'(4'b0001));
      @(negedge clk);
      s_valid[0] = 1'b0;
      m_rvalid   = 1'b1;
      for (int k = 0; k < 8; k++) begin
         #1 chk("full_drain", 64'(s_rvalid), 64'(4'b0001));
         @(negedge clk);
      end
      m_rvalid = 1'b0;

      // Orphan response with an empty tag FIFO
      m_rvalid = 1'b1;
      #1;
      chk("orph_rready", 64'(m_rready),   64'(1'b0));
      chk("orph_rvalid", 64'(s_rvalid),   64'(4'b0000));
      chk("orph_before", 64'(err_orphan), 64'(1'b0));
      @(negedge clk);
      chk("orph_set", 64'(err_orphan), 64'(1'b1));
      m_rvalid = 1'b0;
      @(negedge clk);
      chk("orph_sticky", 64'(err_orphan), 64'(1'b1));

      // Reset mid-flight with 3 tags outstanding (rr_ptr left at 2)
      drive(1, 1'b1, 1'b0, 5'd1);
      #1 chk("mid_rd1", 64'(s_ready), 64'(4'b0010));
      @(negedge clk);
      idle();
      drive(2, 1'b1, 1'b0, 5'd2);
      #1 chk("mid_rd2", 64'(s_ready), 64'(4'b0100));
      @(negedge clk);
      idle();
      drive(1, 1'b1, 1'b0, 5'd3);
      #1 chk("mid_rd3", 64'(s_ready), 64'(4'b0010));
      @(negedge clk);
      idle();
      s_rready = 4'b0000;
      m_rvalid = 1'b1;
      #1 chk("mid_head", 64'(s_rvalid), 64'(4'b0010));
      #1 rst = 1'b1;
      #1;
      chk("mid_rst_rvalid", 64'(s_rvalid),   64'(4'b0000));
      chk("mid_rst_rready", 64'(m_rready),   64'(1'b0));
      chk("mid_rst_orphan", 64'(err_orphan), 64'(1'b0));
      @(negedge clk);
      rst      = 1'b0;
      m_rvalid = 1'b0;
      for (int i = 0; i < 4; i++) drive(i, 1'b1, 1'b1, 5'(i));
      #1 chk("mid_req0_first", 64'(s_ready), 64'(4'b0001));
      idle();
      s_rready = 4'b1111;
      m_rvalid = 1'b1;
      #1;
      chk("mid_fifo_empty_rvalid", 64'(s_rvalid), 64'(4'b0000));
      chk("mid_fifo_empty_rready", 64'(m_rready), 64'(1'b0));
      @(negedge clk);
      m_rvalid = 1'b0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
